// File: rtl/fir_pkg.sv
// Shared FSM type and width helpers for the multi-channel FIR filter.
package fir_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StOut
    } fir_state_e;

    localparam int unsigned MinWidth = 1;

    // Sized so that NUM_TAPS full-scale products can never overflow the accumulator.
    function automatic int unsigned acc_width(int unsigned data_w, int unsigned coeff_w,
                                              int unsigned taps);
        return data_w + coeff_w + $clog2(taps);
    endfunction

    function automatic int unsigned ptr_width(int unsigned taps);
        return (taps > 1) ? $clog2(taps) : MinWidth;
    endfunction

    function automatic int unsigned ch_width(int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : MinWidth;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate; a clear takes priority over accumulation.
module fir_mac
    import fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COEFF_WIDTH = 16,
    parameter int unsigned ACC_WIDTH   = 37
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_en,
    input  logic [DATA_WIDTH-1:0]  i_sample,
    input  logic [COEFF_WIDTH-1:0] i_coeff,
    output logic [ACC_WIDTH-1:0]   o_acc
);

    localparam int unsigned PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;

    logic signed [PROD_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0]         w_prod_ext;
    logic [ACC_WIDTH-1:0]         r_acc;

    assign w_prod     = PROD_WIDTH'($signed(i_sample)) * PROD_WIDTH'($signed(i_coeff));
    assign w_prod_ext = {{(ACC_WIDTH - PROD_WIDTH){w_prod[PROD_WIDTH-1]}}, w_prod};

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/fir_filter_mc.sv
// Time-multiplexed multi-channel FIR: one MAC iterated over NUM_TAPS taps per sample.
// Define FIR_SAT_EN to saturate the scaled output instead of wrapping it.
module fir_filter_mc
    import fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COEFF_WIDTH = 16,
    parameter int unsigned NUM_TAPS    = 32,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned OUT_SHIFT   = 15,
    localparam int unsigned PTR_W      = ptr_width(NUM_TAPS),
    localparam int unsigned CH_W       = ch_width(NUM_CH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_coeff_we,
    input  logic [PTR_W-1:0]       i_coeff_addr,
    input  logic [COEFF_WIDTH-1:0] i_coeff_data,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [CH_W-1:0]        i_in_ch,
    input  logic [DATA_WIDTH-1:0]  i_in_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [CH_W-1:0]        o_out_ch,
    output logic [DATA_WIDTH-1:0]  o_out_data,
    output logic                   o_ch_err
);

    localparam int unsigned ACC_W = acc_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS);
    localparam int unsigned RES_W = ACC_W + 1;

    localparam logic [PTR_W-1:0]        LAST_TAP   = PTR_W'(NUM_TAPS - 1);
    localparam logic [PTR_W-1:0]        TAPS_MOD   = PTR_W'(NUM_TAPS);
    localparam logic [PTR_W:0]          TAPS_EXT   = (PTR_W + 1)'(NUM_TAPS);
    localparam logic [CH_W:0]           NUM_CH_EXT = (CH_W + 1)'(NUM_CH);
    localparam logic signed [RES_W-1:0] ROUND      = (RES_W'(1) << OUT_SHIFT) >> 1;

    fir_state_e             r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_ch_err;
    logic [CH_W-1:0]        r_ch;
    logic [PTR_W-1:0]       r_tap;
    logic [PTR_W-1:0]       r_wptr  [NUM_CH];
    logic [COEFF_WIDTH-1:0] r_coeff [NUM_TAPS];
    logic [DATA_WIDTH-1:0]  r_hist  [NUM_CH][NUM_TAPS];

    logic                   w_accept;
    logic                   w_ch_ok;
    logic                   w_start;
    logic                   w_coeff_wr;
    logic                   w_last;
    logic [PTR_W-1:0]       w_ptr;
    logic [PTR_W-1:0]       w_ptr_next;
    logic [PTR_W-1:0]       w_rd_idx;
    logic [ACC_W-1:0]       w_acc;
    logic signed [RES_W-1:0] w_acc_ext;
    logic signed [RES_W-1:0] w_rounded;
    logic signed [RES_W-1:0] w_scaled;
    logic [DATA_WIDTH-1:0]  w_out_data;

    assign w_accept   = i_in_valid && r_in_ready;
    assign w_ch_ok    = {1'b0, i_in_ch} < NUM_CH_EXT;
    assign w_start    = w_accept && w_ch_ok;
    assign w_coeff_wr = i_coeff_we && (r_state == StIdle) && ({1'b0, i_coeff_addr} < TAPS_EXT);
    assign w_last     = (r_tap == LAST_TAP);
    assign w_ptr      = r_wptr[r_ch];
    assign w_ptr_next = (w_ptr == LAST_TAP) ? '0 : w_ptr + 1'b1;
    // x[n-k] lives at (wptr - k) mod NUM_TAPS; add NUM_TAPS back when the subtraction underflows.
    assign w_rd_idx   = w_ptr - r_tap + ((w_ptr < r_tap) ? TAPS_MOD : '0);

    fir_mac #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COEFF_WIDTH (COEFF_WIDTH),
        .ACC_WIDTH   (ACC_W)
    ) u_mac (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_start),
        .i_en     (r_state == StMac),
        .i_sample (r_hist[r_ch][w_rd_idx]),
        .i_coeff  (r_coeff[r_tap]),
        .o_acc    (w_acc)
    );

    // One extra bit of headroom so the rounding offset cannot wrap the accumulator.
    assign w_acc_ext = $signed({w_acc[ACC_W-1], w_acc});
    assign w_rounded = w_acc_ext + ROUND;
    assign w_scaled  = w_rounded >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [RES_W-1:0] SAT_MAX =
        $signed({{(RES_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}});
    localparam logic signed [RES_W-1:0] SAT_MIN =
        $signed({{(RES_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}});
    localparam logic [DATA_WIDTH-1:0]   OUT_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]   OUT_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    always_comb begin
        w_out_data = w_scaled[DATA_WIDTH-1:0];
        if (w_scaled > SAT_MAX) begin
            w_out_data = OUT_MAX;
        end else if (w_scaled < SAT_MIN) begin
            w_out_data = OUT_MIN;
        end
    end
`else
    logic [RES_W-DATA_WIDTH-1:0] w_unused_hi;

    assign w_out_data  = w_scaled[DATA_WIDTH-1:0];
    assign w_unused_hi = w_scaled[RES_W-1:DATA_WIDTH];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_ch_err    <= 1'b0;
            r_ch        <= '0;
            r_tap       <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_wptr[c] <= '0;
                for (int k = 0; k < NUM_TAPS; k++) begin
                    r_hist[c][k] <= '0;
                end
            end
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_coeff[k] <= '0;
            end
        end else begin
            r_ch_err <= 1'b0;
            // Lands on the accept edge too, so that computation already sees the new value.
            if (w_coeff_wr) begin
                r_coeff[i_coeff_addr] <= i_coeff_data;
            end
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        if (w_ch_ok) begin
                            r_hist[i_in_ch][r_wptr[i_in_ch]] <= i_in_data;
                            r_ch       <= i_in_ch;
                            r_tap      <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= StMac;
                        end else begin
                            r_ch_err <= 1'b1;
                        end
                    end
                end
                StMac: begin
                    r_tap <= r_tap + 1'b1;
                    if (w_last) begin
                        r_wptr[r_ch] <= w_ptr_next;
                        r_out_valid  <= 1'b1;
                        r_state      <= StOut;
                    end
                end
                StOut: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_ch    = r_ch;
    assign o_out_data  = w_out_data;
    assign o_ch_err    = r_ch_err;

endmodule

// File: tb/tb_fir_filter_mc.sv
// Scoreboard bench: two instances (OUT_SHIFT 0 and 1) share stimulus; a tap-list model predicts.
module tb_fir_filter_mc;

    localparam int NT  = 4;
    localparam int NCH = 3;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        coeff_we;
    logic [1:0]  coeff_addr;
    logic [15:0] coeff_data;
    logic        in_valid;
    logic [1:0]  in_ch;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready0, out_valid0, ch_err0;
    logic [1:0]  out_ch0;
    logic [15:0] out_data0;
    logic        in_ready1, out_valid1, ch_err1;
    logic [1:0]  out_ch1;
    logic [15:0] out_data1;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   coef [NT];
    int   hist [NCH][NT];
    exp_t q0 [$];
    exp_t q1 [$];

    fir_filter_mc #(
        .DATA_WIDTH (16), .COEFF_WIDTH (16), .NUM_TAPS (NT), .NUM_CH (NCH), .OUT_SHIFT (0)
    ) dut_s0 (
        .i_clk (clk), .i_rst (rst), .i_coeff_we (coeff_we), .i_coeff_addr (coeff_addr),
        .i_coeff_data (coeff_data), .i_in_valid (in_valid), .o_in_ready (in_ready0),
        .i_in_ch (in_ch), .i_in_data (in_data), .o_out_valid (out_valid0),
        .i_out_ready (out_ready), .o_out_ch (out_ch0), .o_out_data (out_data0),
        .o_ch_err (ch_err0)
    );

    fir_filter_mc #(
        .DATA_WIDTH (16), .COEFF_WIDTH (16), .NUM_TAPS (NT), .NUM_CH (NCH), .OUT_SHIFT (1)
    ) dut_s1 (
        .i_clk (clk), .i_rst (rst), .i_coeff_we (coeff_we), .i_coeff_addr (coeff_addr),
        .i_coeff_data (coeff_data), .i_in_valid (in_valid), .o_in_ready (in_ready1),
        .i_in_ch (in_ch), .i_in_data (in_data), .o_out_valid (out_valid1),
        .i_out_ready (out_ready), .o_out_ch (out_ch1), .o_out_data (out_data1),
        .o_ch_err (ch_err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Round half up, shift, then saturate or wrap to 16 bits.
    function automatic logic [15:0] scale(input longint acc, input int sh);
        longint r;
        r = acc + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0));
        r = r >>> sh;
`ifdef FIR_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    task automatic model_reset();
        foreach (coef[k]) coef[k] = 0;
        foreach (hist[c, k]) hist[c][k] = 0;
        q0.delete();
        q1.delete();
    endtask

    task automatic model_accept(input int ch, input logic [15:0] d);
        longint acc;
        acc = 0;
        for (int k = NT - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
        hist[ch][0] = int'($signed(d));
        for (int k = 0; k < NT; k++) acc += longint'(coef[k]) * longint'(hist[ch][k]);
        q0.push_back({2'(ch), scale(acc, 0)});
        q1.push_back({2'(ch), scale(acc, 1)});
    endtask

    // Monitors: every OUT cycle is compared against the head of the queue (covers stall stability).
    always @(negedge clk) begin
        if (!rst && out_valid0) begin
            check("in_ready_in_out_s0", in_ready0, 0);
            check("out_expected_s0", 64'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                check("out_s0", {out_ch0, out_data0}, q0[0]);
                if (out_ready) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1) begin
            check("in_ready_in_out_s1", in_ready1, 0);
            check("out_expected_s1", 64'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                check("out_s1", {out_ch1, out_data1}, q1[0]);
                if (out_ready) void'(q1.pop_front());
            end
        end
    end

    task automatic write_coeff(input int a, input logic [15:0] d);
        coeff_we   = 1'b1;
        coeff_addr = 2'(a);
        coeff_data = d;
        @(negedge clk);
        coef[a] = int'($signed(d));
        @(posedge clk);
        #1;
        coeff_we = 1'b0;
    endtask

    task automatic send(input int ch, input logic [15:0] d, input bit wr, input int wa,
                        input logic [15:0] wd, input bit mac_wr, input int stall);
        bit seen;
        int k;
        out_ready  = (stall == 0);
        in_valid   = 1'b1;
        in_ch      = 2'(ch);
        in_data    = d;
        coeff_we   = wr;
        coeff_addr = 2'(wa);
        coeff_data = wd;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = in_ready0 && in_ready1;
        end
        check("accept_ready", seen, 1);
        if (wr) coef[wa] = int'($signed(wd));
        if (ch < NCH) model_accept(ch, d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coeff_we = 1'b0;
        if (ch >= NCH) begin
            @(negedge clk);
            check("ch_err_pulse", {ch_err0, ch_err1}, 2'b11);
            check("ch_err_ready", {in_ready0, in_ready1}, 2'b11);
            @(negedge clk);
            check("ch_err_once", {ch_err0, ch_err1, out_valid0, out_valid1}, 0);
            @(posedge clk);
            #1;
            return;
        end
        if (mac_wr) begin
            coeff_we   = 1'b1;
            coeff_addr = 2'($urandom_range(0, NT - 1));
            coeff_data = 16'($urandom);
        end
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            seen = out_valid0;
            if (!seen) begin
                check("busy_flags", {in_ready0, in_ready1, out_valid1}, 0);
                if (mac_wr && k == 1) begin
                    @(posedge clk);
                    #1;
                    coeff_we = 1'b0;
                end
            end
        end
        check("latency", k, NT + 1);
        check("latency_s1", out_valid1, 1);
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("valid_drop", {out_valid0, out_valid1}, 0);
        check("ready_back", {in_ready0, in_ready1}, 2'b11);
        @(posedge clk);
        #1;
    endtask

    task automatic send_s(input int ch, input logic [15:0] d);
        send(ch, d, 1'b0, 0, 16'h0, 1'b0, 0);
    endtask

    task automatic reset_mid_mac();
        in_valid = 1'b1;
        in_ch    = 2'd0;
        in_data  = 16'd9;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < NT + 3; i++) begin
            @(negedge clk);
            check("rst_abort_valid", {out_valid0, out_valid1}, 0);
            check("rst_abort_ready", {in_ready0, in_ready1}, 2'b11);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        coeff_we   = 1'b0;
        coeff_addr = '0;
        coeff_data = '0;
        in_valid   = 1'b0;
        in_ch      = '0;
        in_data    = '0;
        out_ready  = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_s0", {in_ready0, out_valid0, out_ch0, out_data0, ch_err0}, 21'h10_0000);
        check("reset_s1", {in_ready1, out_valid1, out_ch1, out_data1, ch_err1}, 21'h10_0000);
        @(posedge clk);
        #1;

        // Impulse response, then channel isolation with ch1 interleaved.
        for (int k = 0; k < NT; k++) write_coeff(k, 16'(k + 1));
        send_s(0, 16'd1);
        repeat (4) send_s(0, 16'd0);
        send_s(0, 16'd1);
        send_s(1, 16'd5);
        repeat (4) send_s(0, 16'd0);

        // Rounding: c[0]=3 written together with the first accept.
        for (int k = 1; k < NT; k++) write_coeff(k, 16'd0);
        send(2, 16'd1, 1'b1, 0, 16'd3, 1'b0, 0);
        send_s(2, 16'hFFFF);

        // Overflow: full-scale coefficients and samples.
        for (int k = 0; k < NT; k++) write_coeff(k, 16'h7FFF);
        repeat (4) send_s(0, 16'h7FFF);

        // Backpressure with a coefficient write during MAC, then check the set is unchanged.
        send(1, 16'h1234, 1'b0, 0, 16'h0, 1'b1, 10);
        send_s(1, 16'h0100);

        send(3, 16'h5555, 1'b0, 0, 16'h0, 1'b0, 0);

        // Reset mid-MAC: coefficients and histories must come back cleared.
        reset_mid_mac();
        send_s(2, 16'd100);
        for (int k = 0; k < NT; k++) write_coeff(k, 16'(k + 1));
        send_s(0, 16'd1);
        repeat (3) send_s(0, 16'd0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) write_coeff($urandom_range(0, NT - 1), 16'($urandom));
            send($urandom_range(0, 3), 16'($urandom), 1'($urandom_range(0, 3) == 0),
                 $urandom_range(0, NT - 1), 16'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        check("drain_s0", q0.size(), 0);
        check("drain_s1", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
